// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver: hex decode, per-digit enable and dp,
// a blanking interval at the start of each slot, and frame-aligned value updates.
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp,
    input  logic [3:0]  digit_en,
    output logic [7:0]  segOutput,
    output logic [3:0]  anodes,
    output logic        frame_tick
);

    localparam int              PW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]   P_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]   P_BLANK = PW'(BLANK_CYCLES);

    typedef enum logic {
        SLOT_BLANK = 1'b0,
        SLOT_DRIVE = 1'b1
    } slot_e;

    logic [PW-1:0] p_q, p_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   pend_val_q, shad_val_q;
    logic [3:0]    pend_dp_q, shad_dp_q;
    logic          pend_valid_q;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          tick_q;

    logic          slot_end, frame_end;
    logic [3:0]    nibble;
    slot_e         slot_d;

    function automatic logic [6:0] hex_decode(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_end  = (p_q == P_LAST);
        frame_end = slot_end && (idx_q == 2'd3);
        p_d       = slot_end ? '0 : p_q + 1'b1;
        idx_d     = slot_end ? idx_q + 2'd1 : idx_q;
        nibble    = shad_val_q[{idx_q, 2'b00} +: 4];
        // A disabled digit still consumes its slot, keeping the scan rate fixed.
        slot_d    = (p_q >= P_BLANK && digit_en[idx_q]) ? SLOT_DRIVE : SLOT_BLANK;
        an_d      = 4'hF;
        seg_d     = 8'hFF;
        if (slot_d == SLOT_DRIVE) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = {~shad_dp_q[idx_q], hex_decode(nibble)};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p_q          <= '0;
            idx_q        <= 2'd0;
            pend_val_q   <= 16'h0000;
            pend_dp_q    <= 4'b0000;
            pend_valid_q <= 1'b0;
            shad_val_q   <= 16'h0000;
            shad_dp_q    <= 4'b0000;
            seg_q        <= 8'hFF;
            an_q         <= 4'hF;
            tick_q       <= 1'b0;
        end else begin
            p_q    <= p_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            tick_q <= frame_end;
            if (load) begin
                pend_val_q <= value;
                pend_dp_q  <= dp;
            end
            // Shadow only moves on the frame boundary; a coincident load bypasses pending.
            if (frame_end) begin
                pend_valid_q <= 1'b0;
                if (load) begin
                    shad_val_q <= value;
                    shad_dp_q  <= dp;
                end else if (pend_valid_q) begin
                    shad_val_q <= pend_val_q;
                    shad_dp_q  <= pend_dp_q;
                end
            end else if (load) begin
                pend_valid_q <= 1'b1;
            end
        end
    end

    assign segOutput  = seg_q;
    assign anodes     = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: frame-level reference model plus directed literal checks.
module tb_seg7_scan_driver;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FR = 4 * RD;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        load = 1'b0;
    logic [3:0]  dp = 4'b0000;
    logic [3:0]  digit_en = 4'hF;
    logic [7:0]  segOutput;
    logic [3:0]  anodes;
    logic        frame_tick;

    seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clock(clock), .reset_n(reset_n), .value(value), .load(load), .dp(dp),
        .digit_en(digit_en), .segOutput(segOutput), .anodes(anodes), .frame_tick(frame_tick)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [12:0] exp_q[$];
    logic [6:0]  seg_tab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          t_cnt;
    int          last_tick;
    bit          in_reset = 1'b1;
    logic [15:0] cur_val, nxt_val;
    logic [3:0]  cur_dp, nxt_dp;
    logic        nxt_valid;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, req, t_cnt);
        end
    endtask

    task automatic model_reset();
        t_cnt = 0;  last_tick = 0;
        cur_val = 16'h0;  cur_dp = 4'h0;  nxt_val = 16'h0;  nxt_dp = 4'h0;  nxt_valid = 1'b0;
        exp_q.delete();
    endtask

    // Loads during frame f become visible in frame f+1; last load wins.
    task automatic model_edge();
        int p, idx;
        logic [3:0] an, nib;
        logic [7:0] seg;
        logic tick;
        if (in_reset) begin
            exp_q.push_back({1'b0, 4'hF, 8'hFF});
            return;
        end
        p   = t_cnt % RD;
        idx = (t_cnt / RD) % 4;
        nib = 4'((cur_val >> (4 * idx)) & 16'hF);
        an  = 4'hF;
        seg = 8'hFF;
        if (p >= BC && digit_en[idx]) begin
            an[idx] = 1'b0;
            seg = {~cur_dp[idx], seg_tab[nib]};
        end
        tick = (t_cnt % FR) == FR - 1;
        exp_q.push_back({tick, an, seg});
        if (load) begin
            nxt_val = value;  nxt_dp = dp;  nxt_valid = 1'b1;
        end
        if (tick) begin
            if (nxt_valid) begin
                cur_val = nxt_val;  cur_dp = nxt_dp;
            end
            nxt_valid = 1'b0;
        end
        t_cnt++;
    endtask

    task automatic step();
        logic [12:0] e;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        if (exp_q.size() == 0) begin
            check("model_queue_empty", 16'd1, 16'd0);
        end else begin
            e = exp_q.pop_front();
            check("outputs", 16'({frame_tick, anodes, segOutput}), 16'(e));
        end
        if (!in_reset && frame_tick) begin
            if (last_tick != 0) check("tick_period", 16'(t_cnt - last_tick), 16'(FR));
            last_tick = t_cnt;
        end
    endtask

    task automatic lit(input string name, input logic [3:0] an, input logic [7:0] seg);
        check(name, 16'({anodes, segOutput}), 16'({an, seg}));
    endtask

    initial begin
        logic [3:0] kk;
        model_reset();
        // Held in reset from time zero.
        for (int i = 0; i < 3; i++) step();
        reset_n = 1'b1;
        in_reset = 1'b0;
        model_reset();

        for (int n = 1; n <= 160; n++) begin
            step();
            case (n)
                1, 2:    lit("blank_after_reset", 4'hF, 8'hFF);
                3, 8:    lit("digit0_zero", 4'hE, 8'hC0);
                11:      lit("digit1_old_frame", 4'hD, 8'hC0);
                31:      check("no_early_tick", 16'(frame_tick), 16'd0);
                32:      check("first_tick", 16'(frame_tick), 16'd1);
                35:      lit("d0_after_load", 4'hE, 8'h8E);
                43:      lit("d1_after_load_dp", 4'hD, 8'h30);
                51:      lit("d2_after_load", 4'hB, 8'h88);
                59:      lit("d3_after_load", 4'h7, 8'hF9);
                99:      lit("two_loads_last_wins_d0", 4'hE, 8'hA4);
                107:     lit("two_loads_last_wins_d1", 4'hD, 8'hA4);
                131:     lit("boundary_load_next_frame", 4'hE, 8'hB0);
                default: ;
            endcase
            load = (n == 4 || n == 70 || n == 80 || n == 127);
            if (n == 4) begin
                value = 16'h1A3F;  dp = 4'b0010;
            end else if (n == 70) begin
                value = 16'h1111;  dp = 4'b0000;
            end else if (n == 80) begin
                value = 16'h2222;  dp = 4'b0000;
            end else if (n == 127) begin
                value = 16'h3333;  dp = 4'b0000;
            end
        end

        digit_en = 4'b0101;
        for (int i = 0; i < 2 * FR; i++) begin
            step();
            check("disabled_digits_dark", 16'(anodes[1] & anodes[3]), 16'd1);
        end
        digit_en = 4'hF;

        for (int i = 0; i < 40 && (t_cnt % FR) != 20; i++) step();
        lit("digit2_before_reset", 4'hB, 8'hB0);
        #2;
        reset_n = 1'b0;
        in_reset = 1'b1;
        #1;
        check("async_reset_outputs", 16'({frame_tick, anodes, segOutput}), 16'({1'b0, 4'hF, 8'hFF}));
        step();
        step();
        reset_n = 1'b1;
        in_reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) step();
        lit("restart_digit0_cleared", 4'hE, 8'hC0);

        for (int i = 0; i < 800; i++) begin
            step();
            load = ($urandom_range(0, 7) == 0) || (((t_cnt % FR) == FR - 1) && ($urandom_range(0, 1) == 1));
            if (load) begin
                value = 16'($urandom);
                dp = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 49) == 0) digit_en = 4'($urandom_range(0, 15));
        end
        load = 1'b0;
        digit_en = 4'hF;

        for (int k = 0; k < 16; k++) begin
            kk = 4'(k);
            for (int i = 0; i < 40 && (t_cnt % FR) != 5; i++) step();
            value = {12'h000, kk};
            dp = {3'b000, kk[0]};
            load = 1'b1;
            step();
            load = 1'b0;
            for (int i = 0; i < 40 && (t_cnt % FR) != 3; i++) step();
            lit("sweep_digit0", 4'hE, {~kk[0], seg_tab[kk]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
